carregador_de_instrucoes: RTL

Program loader sitting directly upstream of the instruction memory's write port (we/addr/datain). Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into consecutive instruction-memory word addresses. While loading it holds the CPU in reset, then releases it. Used at boot or for reprogramming without resynthesis.

---
 rtl/carregador_de_instrucoes_pkg.sv | 18 +
 rtl/carregador_de_instrucoes_if.sv | 27 ++
 rtl/carregador_de_instrucoes_montador_de_palavra.sv | 31 +++
 rtl/carregador_de_instrucoes.sv | 121 ++++++++++++
 4 files changed

// File: rtl/carregador_de_instrucoes_pkg.sv
// Shared CPU-side definitions for the program loader: state encoding and instruction word width.
// The optional trailer checksum is enabled by defining CARREGADOR_CHECKSUM_EN.
package carregador_de_instrucoes_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERROR  = 3'd7
   } estado_t;

endpackage

// File: rtl/carregador_de_instrucoes_if.sv
// Byte stream in, instruction-memory write port and status out; master is the loader side.
interface carregador_de_instrucoes_if;
   import carregador_de_instrucoes_pkg::*;

   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              we;
   logic [WORD_W-1:0] addr;
   logic [WORD_W-1:0] datain;
   logic              busy;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [15:0]       words_loaded;

   modport master (
      input  start, byte_in, byte_valid,
      output byte_ready, we, addr, datain, busy, cpu_hold, done, err, words_loaded
   );

   modport slave (
      output start, byte_in, byte_valid,
      input  byte_ready, we, addr, datain, busy, cpu_hold, done, err, words_loaded
   );
endinterface

// File: rtl/carregador_de_instrucoes_montador_de_palavra.sv
// Packs accepted bytes big-endian into a 32-bit word; completa fires combinationally with the 4th byte.
// No backpressure of its own: it only sees bytes the loader has already accepted.
module montador_de_palavra
   import carregador_de_instrucoes_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [7:0]        byte_dat,
   output logic [WORD_W-1:0] palavra,
   output logic              completa
);

   logic [23:0] sr;
   logic [1:0]  idx;

   assign palavra  = {sr, byte_dat};
   assign completa = byte_vld && (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sr  <= '0;
         idx <= '0;
      end else if (byte_vld) begin
         sr  <= {sr[15:0], byte_dat};
         idx <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/carregador_de_instrucoes.sv
// Program loader: length-prefixed byte stream -> consecutive instruction-memory writes, CPU held meanwhile.
// we rises 1 cycle after the 4th byte of a word; byte_ready drops in WRITE. Optional CARREGADOR_CHECKSUM_EN adds an XOR trailer.
module carregador_de_instrucoes
   import carregador_de_instrucoes_pkg::*;
#(
   parameter int RAM_SIZE  = 500,
   parameter int BASE_ADDR = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   carregador_de_instrucoes_if.master bus
);

   localparam logic [WORD_W-1:0] LIMITE      = WORD_W'(RAM_SIZE - BASE_ADDR);
   localparam logic [WORD_W-1:0] ULTIMO_ADDR = WORD_W'(RAM_SIZE - 1);
   localparam logic [WORD_W-1:0] BASE        = WORD_W'(BASE_ADDR);

   estado_t           estado, prox;
   logic              aceite;
   logic              inicia;
   logic              completa;
   logic              ultima;
   logic [WORD_W-1:0] palavra;
   logic [WORD_W-1:0] n_ext;
   logic [7:0]        count_hi;
   logic [15:0]       n_palavras;
   logic [15:0]       wl_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] datain_q;
`ifdef CARREGADOR_CHECKSUM_EN
   logic [7:0]        xor_q;
`endif

   assign bus.byte_ready = estado inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK};
   assign aceite         = bus.byte_valid && bus.byte_ready;
   assign inicia         = bus.start && (estado inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign n_ext          = {16'd0, count_hi, bus.byte_in};
   assign ultima         = (wl_q + 16'd1) == n_palavras;

   montador_de_palavra u_montador (
      .clk      (clk),
      .rst      (rst),
      .clr      (estado == ST_LEN_LO),
      .byte_vld (aceite && (estado == ST_DATA)),
      .byte_dat (bus.byte_in),
      .palavra  (palavra),
      .completa (completa)
   );

   always_ff @(posedge clk) begin
      if (rst) estado <= ST_IDLE;
      else     estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         ST_IDLE, ST_DONE, ST_ERROR: if (bus.start) prox = ST_LEN_HI;
         ST_LEN_HI: if (aceite) prox = ST_LEN_LO;
         ST_LEN_LO: begin
            if (aceite) begin
               if (n_ext == '0)         prox = ST_DONE;
               else if (n_ext > LIMITE) prox = ST_ERROR;
               else                     prox = ST_DATA;
            end
         end
         ST_DATA: if (completa) prox = ST_WRITE;
`ifdef CARREGADOR_CHECKSUM_EN
         ST_WRITE: prox = ultima ? ST_CHECK : ST_DATA;
         ST_CHECK: if (aceite) prox = (bus.byte_in == xor_q) ? ST_DONE : ST_ERROR;
`else
         ST_WRITE: prox = ultima ? ST_DONE : ST_DATA;
`endif
         default: prox = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_hi   <= '0;
         n_palavras <= '0;
         wl_q       <= '0;
         addr_q     <= '0;
         datain_q   <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         if (inicia) begin
            wl_q  <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            xor_q <= '0;
`endif
         end
         if (aceite && estado == ST_LEN_HI) count_hi <= bus.byte_in;
         if (aceite && estado == ST_LEN_LO) begin
            n_palavras <= {count_hi, bus.byte_in};
            if (prox == ST_DATA) addr_q <= BASE;
         end
         if (completa) datain_q <= palavra;
`ifdef CARREGADOR_CHECKSUM_EN
         if (aceite && estado == ST_DATA) xor_q <= xor_q ^ bus.byte_in;
`endif
         // Address saturates at the top of memory so it never points past the array.
         if (estado == ST_WRITE) begin
            wl_q <= wl_q + 16'd1;
            if (addr_q != ULTIMO_ADDR) addr_q <= addr_q + 1'b1;
         end
      end
   end

   assign bus.we           = (estado == ST_WRITE);
   assign bus.addr         = addr_q;
   assign bus.datain       = datain_q;
   assign bus.busy         = estado inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_WRITE, ST_CHECK};
   assign bus.cpu_hold     = bus.busy;
   assign bus.done         = (estado == ST_DONE);
   assign bus.err          = (estado == ST_ERROR);
   assign bus.words_loaded = wl_q;

endmodule
